mux_select_sequencer: RTL and testbench
=======================================

Name: mux_select_sequencer

Overview:
- Upstream control stage for the 4:1 select-mux datapath.
- On a start request, steps the 2-bit select through every channel enabled in a mask, holding each select for a programmable dwell time.
- Samples the mux output at the end of each dwell and assembles the four samples into a 4-bit result word.
- Reports completion with a one-cycle done pulse.

Parameters:
- DWELL, 4, cycles each select is held before its sample is taken; legal range 1..2**CW-1.
- CW, 8, width of the dwell counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- ch_mask  input  4  enabled channels (bit n = channel n); latched on accepted start.
- mux_y  input  1  output of the downstream 4:1 mux.
- sel  output  2  select driven to the 4:1 mux.
- sel_valid  output  1  high while sel is stable and being dwelt on.
- busy  output  1  high from accepted start until the cycle before done.
- sample  output  4  captured mux outputs; bit n = value seen on channel n.
- done  output  1  one-cycle pulse at end of scan.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=2'b00, sel_valid=0, busy=0, done=0, sample=4'b0000, counter=0, latched mask=0.
- Reset mid-scan aborts the scan. No done pulse is produced and sample clears.
- FSM states: IDLE, DWELL, NEXT, DONE (2-bit encoding).
- IDLE with start=1 and ch_mask!=0:
  - Latch the mask and clear sample to 0.
  - Set sel to the lowest set mask bit and counter to 0.
  - Go to DWELL.
- IDLE with start=1 and ch_mask=0: clear sample and go directly to DONE.
- DWELL: sel_valid=1, busy=1, counter increments each cycle.
  - When counter==DWELL-1, sample[sel] <= mux_y on that edge, then go to NEXT.
- NEXT: busy=1, sel_valid=0.
  - If the latched mask has a set bit above sel, sel <= lowest such bit, counter <= 0, go to DWELL.
  - Otherwise go to DONE; sel holds its last value.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. sample holds until the next accepted start.
- Latency: with N enabled channels, done is high in the cycle starting N*(DWELL+1) edges after the edge that accepted start. A zero mask gives done 1 edge after.
- start while not IDLE is ignored, including during the DONE cycle. start held high in IDLE re-triggers a new scan immediately after DONE.
- Changes to ch_mask during a scan are ignored; only the latched copy is used.
- DWELL=1: capture occurs on the first DWELL cycle; no extra wait.
- Channels are always visited in ascending order. Disabled channels are skipped with no dwell, and their sample bits stay 0.
- The counter never wraps within legal DWELL; it resets to 0 on every channel entry.
- All outputs are registered; no combinational path from mux_y or start to any output.

Decomposition:
- Shared package holds:
  - state enum constants (IDLE=2'd0, DWELL=2'd1, NEXT=2'd2, DONE=2'd3);
  - NUM_CH=4;
  - SEL_W=2.
- One natural sub-module: next_channel_finder, a combinational priority search that takes (mask, current sel) and returns (found, next sel). It is instantiated twice: first-channel search with current=-1 semantics, and in NEXT.

Test Plan:
- Reset async mid-DWELL (rst pulse between edges) -> sel=00, busy=0, sample=0000 immediately; no done.
- mask=1111, DWELL=4, mux_y driven as channel pattern 1,0,1,1 per sel -> sel steps 00,01,10,11; sample=4'b1101; done 20 edges after start.
- mask=1010, DWELL=4, mux_y=1 constant -> sel visits 01 then 11 only; sample=4'b1010; done after 10 edges.
- mask=0000 with start -> done pulses 1 edge later; busy never high; sample=0000.
- start pulsed during DWELL, with mask changed to 0001 mid-scan (original mask 1100) -> scan unaffected; sample bits only at 2,3.
- DWELL=1, mask=0110, mux_y toggling every cycle -> sample captures the value present on the single dwell edge of each channel; done after 4 edges.

Source files
------------

// File: rtl/mux_select_sequencer_pkg.sv
// mux_select_sequencer_pkg: shared constants and FSM state type for the select sequencer
// Ports: none (package).
package mux_select_sequencer_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DWELL = 2'd1,
      S_NEXT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/mux_select_sequencer_next_channel_finder.sv
// mux_select_sequencer_next_channel_finder: priority search for the lowest enabled channel above cur
// Ports: mask  - enabled channels
//        cur   - current select
//        first - ignore cur and search from channel 0 (cur = -1)
//        found - an enabled channel exists in the search range
//        nxt   - lowest such channel
module mux_select_sequencer_next_channel_finder
   import mux_select_sequencer_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              first,
   output logic              found,
   output logic [SEL_W-1:0]  nxt
);
   // Descending scan so the lowest qualifying channel is assigned last and wins.
   always_comb begin
      found = 1'b0;
      nxt = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i] && (first || i > int'(cur))) begin
            found = 1'b1;
            nxt = SEL_W'(i);
         end
   end
endmodule

// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: steps a 4:1 mux select through masked channels, samples each after a dwell
// Ports: clk, rst (async active-high)
//        start, ch_mask - scan request and channel enables (latched on accept)
//        mux_y          - downstream mux output
//        sel, sel_valid - select to the mux and its dwell qualifier
//        busy, done     - scan in progress / one-cycle completion pulse
//        sample         - captured value per channel
module mux_select_sequencer
   import mux_select_sequencer_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int CW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              mux_y,
   output logic [SEL_W-1:0]  sel,
   output logic              sel_valid,
   output logic              busy,
   output logic [NUM_CH-1:0] sample,
   output logic              done
);
   state_t            state;
   logic [CW-1:0]     cnt;
   logic [NUM_CH-1:0] mask_q;
   logic              first_found, next_found;
   logic [SEL_W-1:0]  first_sel, next_sel;

   // First channel comes from the live mask so the accept edge can load sel directly.
   mux_select_sequencer_next_channel_finder u_first (
      .mask(ch_mask), .cur('0), .first(1'b1), .found(first_found), .nxt(first_sel)
   );

   mux_select_sequencer_next_channel_finder u_next (
      .mask(mask_q), .cur(sel), .first(1'b0), .found(next_found), .nxt(next_sel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         sel       <= '0;
         sel_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sample    <= '0;
         cnt       <= '0;
         mask_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sample <= '0;
                  if (first_found) begin
                     mask_q    <= ch_mask;
                     sel       <= first_sel;
                     cnt       <= '0;
                     sel_valid <= 1'b1;
                     busy      <= 1'b1;
                     state     <= S_DWELL;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DWELL: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(DWELL - 1)) begin
                  sample[sel] <= mux_y;
                  sel_valid   <= 1'b0;
                  state       <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (next_found) begin
                  sel       <= next_sel;
                  cnt       <= '0;
                  sel_valid <= 1'b1;
                  state     <= S_DWELL;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb_mux_select_sequencer: directed scoreboard bench for the select sequencer (DWELL=4 and DWELL=1 instances)
module tb_mux_select_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, start1 = 1'b0;
   logic [3:0] ch_mask = '0, ch_mask1 = '0;
   logic [3:0] pat = '0;
   logic       mux_y, mux_y1 = 1'b0;
   logic [1:0] sel, sel1;
   logic       sel_valid, sel_valid1, busy, busy1, done, done1;
   logic [3:0] sample, sample1;
   int         checks = 0;
   int         errors = 0;

   typedef struct {
      logic [3:0] smp;
      int         lat;
      logic [7:0] seq;
      int         n;
      logic [1:0] last;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   // Behavioural 4:1 mux: pat bit n is the value presented on channel n.
   assign mux_y = pat[sel];

   mux_select_sequencer #(.DWELL(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .mux_y(mux_y),
      .sel(sel), .sel_valid(sel_valid), .busy(busy), .sample(sample), .done(done)
   );

   mux_select_sequencer #(.DWELL(1), .CW(8)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .ch_mask(ch_mask1), .mux_y(mux_y1),
      .sel(sel1), .sel_valid(sel_valid1), .busy(busy1), .sample(sample1), .done(done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] m, input logic [3:0] p, input int d);
      exp_t e;
      e.smp = m & p;
      e.seq = '0;
      e.n = 0;
      e.last = '0;
      for (int i = 0; i < 4; i++)
         if (m[i]) begin
            e.seq[2*e.n +: 2] = 2'(i);
            e.n++;
            e.last = 2'(i);
         end
      e.lat = (m == 0) ? 0 : e.n * (d + 1);
      return e;
   endfunction

   task automatic run(input string tag, input logic [3:0] m, input logic [3:0] p, input bit mid);
      exp_t e;
      logic [7:0] seq = '0;
      int n = 0, k = 0;
      bit prev_v = 0, busy_bad = 0;
      exp_q.push_back(model(m, p, 4));
      @(negedge clk);
      ch_mask = m;
      pat = p;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      while (!done && k < 200) begin
         if (mid && k == 1) begin
            start = 1'b1;
            ch_mask = 4'b0001;
         end
         if (mid && k == 2) start = 1'b0;
         if (sel_valid && !prev_v && n < 4) begin
            seq[2*n +: 2] = sel;
            n++;
         end
         prev_v = sel_valid;
         if (busy !== 1'b1) busy_bad = 1;
         @(posedge clk);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 32'(done), 32'd1);
      e = exp_q.pop_front();
      chk({tag, "_latency"}, 32'(k), 32'(e.lat));
      chk({tag, "_sample"}, 32'(sample), 32'(e.smp));
      chk({tag, "_sel_seq"}, 32'(seq), 32'(e.seq));
      chk({tag, "_sel_cnt"}, 32'(n), 32'(e.n));
      chk({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (m != 0) chk({tag, "_sel_hold"}, 32'(sel), 32'(e.last));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_sample_hold"}, 32'(sample), 32'(e.smp));
   endtask

   initial begin
      exp_t e;
      bit saw_done;
      int k;
      logic [3:0] v;
      #1;
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(sel_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sample", 32'(sample), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run("all4", 4'b1111, 4'b1101, 0);
      run("m1010", 4'b1010, 4'b1111, 0);
      run("zero", 4'b0000, 4'b1111, 0);
      run("midchg", 4'b1100, 4'b1111, 1);

      // Async reset in the middle of channel 1's dwell.
      @(negedge clk);
      ch_mask = 4'b1111;
      pat = 4'b1101;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("prerst_sample", 32'(sample), 32'h1);
      chk("prerst_sel", 32'(sel), 32'h1);
      rst = 1'b1;
      #1;
      chk("arst_sel", 32'(sel), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(sel_valid), 32'd0);
      chk("arst_sample", 32'(sample), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      chk("arst_no_done", 32'(saw_done), 32'd0);

      // DWELL=1 instance, mux_y1 toggles every cycle; capture edges are 1 and 3 after accept.
      v[0] = 1'b1;
      v[1] = 1'b0;
      v[2] = 1'b1;
      e.smp = {1'b0, v[2], v[0], 1'b0};
      e.lat = 4;
      exp_q.push_back(e);
      @(negedge clk);
      mux_y1 = 1'b0;
      ch_mask1 = 4'b0110;
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      k = 0;
      mux_y1 = ~mux_y1;
      while (!done1 && k < 50) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         mux_y1 = ~mux_y1;
      end
      e = exp_q.pop_front();
      chk("d1_done_seen", 32'(done1), 32'd1);
      chk("d1_latency", 32'(k), 32'(e.lat));
      chk("d1_sample", 32'(sample1), 32'(e.smp));
      chk("d1_sel_hold", 32'(sel1), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
